data_mem_responder: RTL and testbench

Memory-side responder for the CPU data-memory port. It replaces the single-cycle array with a ready/valid request/response slave that has a configurable access latency. It supports byte, half and word loads and stores, with sign or zero extension on loads, and it flags misaligned or out-of-range accesses. It sits behind the MEM stage, which acts as initiator and stalls on `req_ready` or `resp_valid`. It is the building block for later stall/bus work.

---
 rtl/data_mem_pkg.sv | 6 +
 rtl/mem_lane_align.sv | 28 ++
 rtl/data_mem_responder.sv | 114 +++++++++++
 tb/tb_data_mem_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types and constants for the data-memory responder
package data_mem_pkg;
  typedef enum logic [1:0] {SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10} mem_size_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmr_state_e;
  localparam int OFFSET_BITS = 2;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte/half lane merge for stores and lane extract plus extension for loads
module mem_lane_align
  import data_mem_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic [BIT_WIDTH-1:0]   word,
  input  logic [BIT_WIDTH-1:0]   wdata,
  input  logic [1:0]             size,
  input  logic [OFFSET_BITS-1:0] offset,
  input  logic                   uns,
  output logic [BIT_WIDTH-1:0]   merged,
  output logic [BIT_WIDTH-1:0]   ext
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  always_comb begin
    merged = word;
    if (size == SIZE_B) merged[{offset, 3'b000} +: 8] = wdata[7:0];
    else if (size == SIZE_H) merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
    else merged = wdata;
  end
  assign lane_b = word[{offset, 3'b000} +: 8];
  assign lane_h = word[{offset[1], 4'b0000} +: 16];
  assign ext = size == SIZE_W ? word
             : size == SIZE_H ? {{(BIT_WIDTH-16){~uns & lane_h[15]}}, lane_h}
             : {{(BIT_WIDTH-8){~uns & lane_b[7]}}, lane_b};
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: ready/valid data-memory slave with fixed access latency and fault checking
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int BIT_WIDTH   = 32,
  parameter int ENTRY_COUNT = 32,
  parameter int LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [31:0]          req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic                 resp_err
);
  localparam int CW = $clog2(LATENCY + 1);
  localparam int IW = ENTRY_COUNT > 1 ? $clog2(ENTRY_COUNT) : 1;
  dmr_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [1:0]           size_q, size_d;
  logic [31:0]          addr_q, addr_d;
  logic [BIT_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [BIT_WIDTH-1:0] mem_q [ENTRY_COUNT];
  logic [BIT_WIDTH-1:0] word, merged, ext;
  logic [IW-1:0]        idx;
  logic                 err, wr_en;
  assign idx  = addr_q[IW+1:2];
  assign word = mem_q[idx];
  // Range check uses the full word index so aliasing addresses above the array fault
  assign err = size_q == 2'b11
            || (size_q == SIZE_H && addr_q[0])
            || (size_q == SIZE_W && addr_q[1:0] != 2'b00)
            || {2'b00, addr_q[31:2]} >= 32'(ENTRY_COUNT);
  mem_lane_align #(.BIT_WIDTH(BIT_WIDTH)) u_align (
    .word   (word),
    .wdata  (wdata_q),
    .size   (size_q),
    .offset (addr_q[OFFSET_BITS-1:0]),
    .uns    (uns_q),
    .merged (merged),
    .ext    (ext)
  );
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        size_d  = req_size;
        uns_d   = req_unsigned;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        cnt_d   = CW'(LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          wr_en   = we_q & ~err;
          rdata_d = (we_q | err) ? '0 : ext;
          err_d   = err;
          state_d = RESP;
        end
      end
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < ENTRY_COUNT; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (wr_en) mem_q[idx] <= merged;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: vector table plus scoreboard bench for LATENCY 2 and LATENCY 1 builds
module tb_data_mem_responder;
  localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2, X = 2'd3;
  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic        req_valid = 0, req_we = 0, req_unsigned = 0, resp_ready = 1;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        req_valid1 = 0, req_we1 = 0, req_unsigned1 = 0, resp_ready1 = 1;
  logic [1:0]  req_size1 = 0;
  logic [31:0] req_addr1 = 0, req_wdata1 = 0;
  logic        req_ready1, resp_valid1, resp_err1;
  logic [31:0] resp_rdata1;
  data_mem_responder #(.BIT_WIDTH(32), .ENTRY_COUNT(32), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );
  data_mem_responder #(.BIT_WIDTH(32), .ENTRY_COUNT(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_size(req_size1), .req_unsigned(req_unsigned1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );
  int    checks = 0, failures = 0, cyc = 0, acc_cyc = 0;
  string cur_name = "none";
  logic  prev_valid = 0;
  exp_t  exp_q[$];
  vec_t  vecs[$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(string nm, logic we, logic [1:0] sz, logic u, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] rd, logic e);
    vec_t v;
    v.name = nm; v.we = we; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd; v.rdata = rd; v.err = e;
    return v;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (rst && resp_valid && !prev_valid) chk({cur_name, "_latency"}, cyc - acc_cyc, 32'd2);
    if (rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_unexpected_resp: got rdata %h with no pending request", cur_name, resp_rdata);
      end else begin
        e = exp_q.pop_front();
        chk({cur_name, "_rdata"}, resp_rdata, e.rdata);
        chk({cur_name, "_err"}, 32'(resp_err), 32'(e.err));
      end
    end
    prev_valid = resp_valid;
  end
  task automatic issue(input vec_t v);
    int n = 0;
    cur_name     = v.name;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_valid    = 1'b1;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL %s_accept: got req_ready 0 expected 1 within 50 cycles", v.name);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    exp_q.push_back('{v.rdata, v.err});
    req_valid    = 1'b0;
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk({cur_name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask
  initial begin
    int   n;
    logic seen;
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end
  initial begin
    int   n;
    logic seen;
    vecs.push_back(mk("sw_10",       1, W, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0));
    vecs.push_back(mk("lw_10",       0, W, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0));
    vecs.push_back(mk("sb_13",       1, B, 0, 32'h13, 32'h5A5A5A80, 32'h0,        0));
    vecs.push_back(mk("lb_13",       0, B, 0, 32'h13, 32'h0,        32'hFFFFFF80, 0));
    vecs.push_back(mk("lbu_13",      0, B, 1, 32'h13, 32'h0,        32'h00000080, 0));
    vecs.push_back(mk("lw_10b",      0, W, 0, 32'h10, 32'h0,        32'h80ADBEEF, 0));
    vecs.push_back(mk("lh_12",       0, H, 0, 32'h12, 32'h0,        32'hFFFF80AD, 0));
    vecs.push_back(mk("lhu_12",      0, H, 1, 32'h12, 32'h0,        32'h000080AD, 0));
    vecs.push_back(mk("lb_10",       0, B, 0, 32'h10, 32'h0,        32'hFFFFFFEF, 0));
    vecs.push_back(mk("lbu_11",      0, B, 1, 32'h11, 32'h0,        32'h000000BE, 0));
    vecs.push_back(mk("lh_10",       0, H, 0, 32'h10, 32'h0,        32'hFFFFBEEF, 0));
    vecs.push_back(mk("lwu_10",      0, W, 1, 32'h10, 32'h0,        32'h80ADBEEF, 0));
    vecs.push_back(mk("lw_02_mis",   0, W, 0, 32'h02, 32'h0,        32'h0,        1));
    vecs.push_back(mk("sh_11_mis",   1, H, 0, 32'h11, 32'h1234,     32'h0,        1));
    vecs.push_back(mk("sw_12_mis",   1, W, 0, 32'h12, 32'hFFFFFFFF, 32'h0,        1));
    vecs.push_back(mk("lw_10_after", 0, W, 0, 32'h10, 32'h0,        32'h80ADBEEF, 0));
    vecs.push_back(mk("lw_80_oor",   0, W, 0, 32'h80, 32'h0,        32'h0,        1));
    vecs.push_back(mk("sb_80_oor",   1, B, 0, 32'h80, 32'hFF,       32'h0,        1));
    vecs.push_back(mk("lw_00",       0, W, 0, 32'h00, 32'h0,        32'h0,        0));
    vecs.push_back(mk("size3",       0, X, 0, 32'h10, 32'h0,        32'h0,        1));
    vecs.push_back(mk("sh_16",       1, H, 0, 32'h16, 32'hAAAACAFE, 32'h0,        0));
    vecs.push_back(mk("lw_14",       0, W, 0, 32'h14, 32'h0,        32'hCAFE0000, 0));
    vecs.push_back(mk("sw_7c",       1, W, 0, 32'h7C, 32'h01020304, 32'h0,        0));
    vecs.push_back(mk("lb_7f",       0, B, 0, 32'h7F, 32'h0,        32'h00000001, 0));
    vecs.push_back(mk("lw_7c",       0, W, 0, 32'h7C, 32'h0,        32'h01020304, 0));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready",   32'(req_ready),  1);
    chk("rst_resp_valid",  32'(resp_valid), 0);
    chk("rst_resp_rdata",  resp_rdata,      0);
    chk("rst_resp_err",    32'(resp_err),   0);
    chk("rst1_req_ready",  32'(req_ready1), 1);
    chk("rst1_resp_valid", 32'(resp_valid1), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    foreach (vecs[i]) begin
      issue(vecs[i]);
      wait_idle();
    end
    // Backpressure: response held five cycles while a second request waits
    resp_ready = 1'b0;
    issue(mk("bp_lw_10", 0, W, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0));
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    req_we = 0; req_size = W; req_unsigned = 0; req_addr = 32'h14; req_wdata = 32'h0; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", 32'(resp_valid), 1);
      chk("bp_resp_rdata", resp_rdata,      32'h80ADBEEF);
      chk("bp_resp_err",   32'(resp_err),   0);
      chk("bp_req_ready",  32'(req_ready),  0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_req_ready",  32'(req_ready),  1);
    chk("bp_idle_resp_valid", 32'(resp_valid), 0);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    cur_name = "bp_pending_lw_14";
    exp_q.push_back('{32'hCAFE0000, 1'b0});
    chk("bp_pending_accepted", 32'(req_ready), 0);
    req_valid = 1'b0;
    wait_idle();
    // Reset during WAIT aborts the store and clears storage
    cur_name = "rst_mid";
    req_we = 1; req_size = W; req_unsigned = 0; req_addr = 32'h04; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen |= resp_valid;
      @(posedge clk); #1;
    end
    chk("rst_mid_no_resp",   32'(seen),      0);
    chk("rst_mid_req_ready", 32'(req_ready), 1);
    issue(mk("rst_lw_04", 0, W, 0, 32'h04, 32'h0, 32'h0, 0));
    wait_idle();
    issue(mk("rst_lw_10", 0, W, 0, 32'h10, 32'h0, 32'h0, 0));
    wait_idle();
    // LATENCY=1 build, back-to-back with resp_ready tied high
    req_we1 = 1; req_size1 = W; req_unsigned1 = 0; req_addr1 = 32'h08; req_wdata1 = 32'hA5A5A5A5;
    req_valid1 = 1'b1;
    @(posedge clk); #1;
    chk("l1_sw_accepted",   32'(req_ready1),  0);
    chk("l1_sw_no_resp",    32'(resp_valid1), 0);
    req_we1 = 0; req_addr1 = 32'h08; req_wdata1 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    chk("l1_sw_resp_valid", 32'(resp_valid1), 1);
    chk("l1_sw_resp_rdata", resp_rdata1,      0);
    chk("l1_sw_resp_err",   32'(resp_err1),   0);
    @(posedge clk); #1;
    chk("l1_idle_req_ready",  32'(req_ready1),  1);
    chk("l1_idle_resp_valid", 32'(resp_valid1), 0);
    @(posedge clk); #1;
    chk("l1_lw_accepted", 32'(req_ready1), 0);
    req_valid1 = 1'b0;
    req_addr1  = 32'h0;
    @(posedge clk); #1;
    chk("l1_lw_resp_valid", 32'(resp_valid1), 1);
    chk("l1_lw_resp_rdata", resp_rdata1,      32'hA5A5A5A5);
    chk("l1_lw_resp_err",   32'(resp_err1),   0);
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
